shift_unpacker: RTL and testbench

//   Parallel-in/serial-out shift register with valid/ready handshakes on both sides.

---
 rtl/shift_unpacker_if.sv | 25 ++
 rtl/shift_unpacker.sv | 75 +++++++
 tb/tb_shift_unpacker.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/shift_unpacker_if.sv
// Handshake bundle for shift_unpacker: wide word in, N-bit beats out.
// The master side drives the word and the downstream ready; the slave side is the unpacker.
interface shift_unpacker_if #(
    parameter int N      = 8,
    parameter int Length = 4
);
    logic [N*Length-1:0] data_i;
    logic                valid_i;
    logic                ready_o;
    logic [N-1:0]        data_o;
    logic                valid_o;
    logic                ready_i;
    logic                last_o;
    logic                busy_o;

    modport master (
        output data_i, valid_i, ready_i,
        input  ready_o, data_o, valid_o, last_o, busy_o
    );

    modport slave (
        input  data_i, valid_i, ready_i,
        output ready_o, data_o, valid_o, last_o, busy_o
    );
endinterface

// File: rtl/shift_unpacker.sv
// Parallel-in/serial-out unpacker: loads one Length*N-bit word and emits Length
// N-bit beats, element 0 first, with valid/ready on both sides.
module shift_unpacker #(
    parameter int N      = 8,
    parameter int Length = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    shift_unpacker_if.slave      bus
);
    localparam int IW = (Length > 1) ? $clog2(Length) : 1;

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t                   r_state;
    logic [Length-1:0][N-1:0] r_store;
    logic [IW-1:0]            r_idx;

    logic w_last_idx;
    logic w_load;
    logic w_beat;

    assign w_last_idx = (r_idx == IW'(Length - 1));

    // Ready looks through to ready_i on the final beat so words chain without a bubble.
    assign bus.ready_o = !rst_i && ((r_state == IDLE) ||
                                    ((r_state == SHIFT) && w_last_idx && bus.ready_i));

    assign w_load = bus.valid_i && bus.ready_o;
    assign w_beat = bus.valid_o && bus.ready_i;

    assign bus.data_o  = r_store[0];
    assign bus.valid_o = (r_state == SHIFT);
    assign bus.busy_o  = (r_state == SHIFT);
    assign bus.last_o  = (r_state == SHIFT) && w_last_idx;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_store <= '0;
            r_idx   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_load) begin
                        r_store <= bus.data_i;
                        r_idx   <= '0;
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    // A load on the final beat takes priority over the shift.
                    if (w_load) begin
                        r_store <= bus.data_i;
                        r_idx   <= '0;
                    end else if (w_beat) begin
                        for (int k = 0; k < Length - 1; k++) begin
                            r_store[k] <= r_store[k+1];
                        end
                        r_store[Length-1] <= '0;
                        if (w_last_idx) begin
                            r_idx   <= '0;
                            r_state <= IDLE;
                        end else begin
                            r_idx <= r_idx + IW'(1);
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_shift_unpacker.sv
// Bench for shift_unpacker: queue-based beat model checked every cycle, plus directed
// literal checks and a randomized valid/ready soak.
module tb_shift_unpacker;
    typedef struct {
        logic [7:0] d;
        logic       l;
        int         c;
    } beat_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    shift_unpacker_if #(.N(8), .Length(4)) b8 ();
    shift_unpacker_if #(.N(8), .Length(1)) b1 ();

    shift_unpacker #(.N(8), .Length(4)) u8 (.clk_i(clk), .rst_i(rst), .bus(b8.slave));
    shift_unpacker #(.N(8), .Length(1)) u1 (.clk_i(clk), .rst_i(rst), .bus(b1.slave));

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    beat_t q8[$], q1[$], obs8[$], obs1[$];
    beat_t t8, t1;
    int    nload8 = 0, nbeat8 = 0, nlast8 = 0, nload1 = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Model: pending beats of the word in flight; front of queue is the beat on data_o.
    always @(negedge clk) begin
        chk("u8 ready_o", b8.ready_o, !rst && (q8.size() == 0 || (q8.size() == 1 && b8.ready_i)));
        chk("u8 valid_o", b8.valid_o, q8.size() != 0);
        chk("u8 busy_o", b8.busy_o, q8.size() != 0);
        chk("u8 data_o", b8.data_o, q8.size() != 0 ? q8[0].d : 8'h00);
        chk("u8 last_o", b8.last_o, q8.size() != 0 ? q8[0].l : 1'b0);
        if (rst) begin
            q8.delete();
        end else begin
            if (b8.valid_o && b8.ready_i && q8.size() != 0) begin
                t8 = q8.pop_front();
                t8.c = cyc;
                obs8.push_back(t8);
                nbeat8++;
                if (t8.l) nlast8++;
            end
            if (b8.valid_i && b8.ready_o) begin
                for (int k = 0; k < 4; k++) q8.push_back('{d: b8.data_i[k*8 +: 8], l: (k == 3), c: 0});
                nload8++;
            end
        end
    end

    always @(negedge clk) begin
        chk("u1 ready_o", b1.ready_o, !rst && (q1.size() == 0 || (q1.size() == 1 && b1.ready_i)));
        chk("u1 valid_o", b1.valid_o, q1.size() != 0);
        chk("u1 data_o", b1.data_o, q1.size() != 0 ? q1[0].d : 8'h00);
        chk("u1 last_o", b1.last_o, q1.size() != 0);
        if (rst) begin
            q1.delete();
        end else begin
            if (b1.valid_o && b1.ready_i && q1.size() != 0) begin
                t1 = q1.pop_front();
                t1.c = cyc;
                obs1.push_back(t1);
            end
            if (b1.valid_i && b1.ready_o) begin
                q1.push_back('{d: b1.data_i, l: 1'b1, c: 0});
                nload1++;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, n0, words, b0, l0;
        logic [31:0] wa, wb;
        logic [7:0] exp_d;
        rst = 1'b1;
        b8.data_i = '0; b8.valid_i = 1'b0; b8.ready_i = 1'b1;
        b1.data_i = '0; b1.valid_i = 1'b0; b1.ready_i = 1'b1;
        repeat (3) step();
        chk("reset ready_o", b8.ready_o, 1'b0);
        rst = 1'b0;
        #1;
        chk("post-reset ready_o", b8.ready_o, 1'b1);
        chk("post-reset valid_o", b8.valid_o, 1'b0);
        chk("post-reset data_o", b8.data_o, 8'h00);
        chk("post-reset busy_o", b8.busy_o, 1'b0);
        chk("post-reset last_o", b8.last_o, 1'b0);

        // T1: single word, free-running downstream
        obs8.delete();
        t0 = cyc;
        b8.data_i = 32'h44332211; b8.valid_i = 1'b1;
        step();
        b8.valid_i = 1'b0;
        repeat (6) step();
        chk("T1 beat count", obs8.size(), 4);
        if (obs8.size() == 4) begin
            for (int k = 0; k < 4; k++) begin
                exp_d = 8'h11 * 8'(k + 1);
                chk("T1 data", obs8[k].d, exp_d);
                chk("T1 last", obs8[k].l, k == 3);
                chk("T1 cycle", obs8[k].c, t0 + 1 + k);
            end
        end

        // T2: two words back-to-back
        obs8.delete();
        wa = 32'hD4C3B2A1; wb = 32'h08070605;
        n0 = nload8;
        b8.data_i = wa; b8.valid_i = 1'b1;
        step();
        b8.data_i = wb;
        for (int i = 0; i < 20 && nload8 < n0 + 2; i++) step();
        chk("T2 second load taken", nload8, n0 + 2);
        b8.valid_i = 1'b0;
        repeat (8) step();
        chk("T2 beat count", obs8.size(), 8);
        if (obs8.size() == 8) begin
            for (int k = 0; k < 8; k++) begin
                exp_d = (k < 4) ? wa[k*8 +: 8] : wb[(k-4)*8 +: 8];
                chk("T2 data", obs8[k].d, exp_d);
                chk("T2 no gap", obs8[k].c, obs8[0].c + k);
            end
        end

        // T3: backpressure on beat 22
        b8.data_i = 32'h44332211; b8.valid_i = 1'b1;
        step();
        b8.valid_i = 1'b0;
        step();
        chk("T3 beat 22 shown", b8.data_o, 8'h22);
        b8.ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("T3 hold data", b8.data_o, 8'h22);
            chk("T3 hold last", b8.last_o, 1'b0);
            chk("T3 ready_o low", b8.ready_o, 1'b0);
        end
        b8.ready_i = 1'b1;
        step();
        chk("T3 resume 33", b8.data_o, 8'h33);
        repeat (4) step();

        // T4: reset during beat 33
        obs8.delete();
        b8.data_i = 32'h44332211; b8.valid_i = 1'b1;
        step();
        b8.valid_i = 1'b0;
        repeat (2) step();
        chk("T4 at beat 33", b8.data_o, 8'h33);
        rst = 1'b1;
        step();
        chk("T4 valid_o", b8.valid_o, 1'b0);
        chk("T4 data_o", b8.data_o, 8'h00);
        chk("T4 busy_o", b8.busy_o, 1'b0);
        chk("T4 ready_o in reset", b8.ready_o, 1'b0);
        rst = 1'b0;
        repeat (3) step();
        chk("T4 beats before reset", obs8.size(), 2);
        obs8.delete();
        b8.data_i = 32'h44332211; b8.valid_i = 1'b1;
        step();
        b8.valid_i = 1'b0;
        repeat (5) step();
        chk("T4 restart count", obs8.size(), 4);
        if (obs8.size() != 0) chk("T4 restart element 0", obs8[0].d, 8'h11);

        // T5: Length=1 pipeline register
        obs1.delete();
        t0 = cyc;
        b1.data_i = 8'hAA; b1.valid_i = 1'b1;
        step();
        b1.data_i = 8'hBB;
        step();
        b1.data_i = 8'hCC;
        step();
        b1.valid_i = 1'b0;
        repeat (3) step();
        chk("T5 beat count", obs1.size(), 3);
        if (obs1.size() == 3) begin
            for (int k = 0; k < 3; k++) begin
                exp_d = 8'hAA + 8'(k * 8'h11);
                chk("T5 data", obs1[k].d, exp_d);
                chk("T5 last", obs1[k].l, 1'b1);
                chk("T5 cycle", obs1[k].c, t0 + 1 + k);
            end
        end

        // T6: random valid/ready soak
        obs8.delete();
        words = 0; b0 = nbeat8; l0 = nlast8;
        for (int cy = 0; cy < 20000 && words < 1000; cy++) begin
            if (!b8.valid_i && $urandom_range(2) != 0) begin
                b8.valid_i = 1'b1;
                b8.data_i = $urandom;
            end
            b8.ready_i = ($urandom_range(3) != 0);
            n0 = nload8;
            step();
            if (nload8 != n0) begin
                words++;
                b8.valid_i = 1'b0;
            end
        end
        b8.valid_i = 1'b0;
        b8.ready_i = 1'b1;
        repeat (10) step();
        chk("T6 words loaded", words, 1000);
        chk("T6 drained", q8.size(), 0);
        chk("T6 beat total", nbeat8 - b0, 4 * words);
        chk("T6 last total", nlast8 - l0, words);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
